i2c_target: RTL and testbench

I2C_TARGET -- requirements
Module: i2c_target

---
 rtl/i2c_pkg.sv | 20 ++
 rtl/i2c_sync_edge.sv | 24 ++
 rtl/i2c_target.sv | 147 ++++++++++++++
 tb/tb_i2c_target.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C register target: FSM state encoding and the
// default bus address.
package i2c_pkg;

  localparam logic [6:0] DEFAULT_TARGET_ADDR = 7'h40;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    REG,
    REG_ACK,
    WDATA,
    WDATA_ACK,
    RDATA,
    RDATA_ACK,
    IGNORE
  } state_e;

endpackage

// File: rtl/i2c_sync_edge.sv
// Two-flop synchronizer plus a delay flop; reports the synchronized level and
// its rising/falling edges. Resets to 1 so an idle bus produces no edges.
module i2c_sync_edge (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  // ff[0]: metastability stage, ff[1]: synchronized, ff[2]: previous value
  logic [2:0] ff;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ff <= '1;
    else         ff <= {ff[1:0], d};
  end

  assign q    = ff[1];
  assign rise = ff[1] & ~ff[2];
  assign fall = ~ff[1] & ff[2];

endmodule

// File: rtl/i2c_target.sv
// I2C register target: 7-bit address, one pointer byte, then write or read data.
// Define I2C_TARGET_AUTOINC_EN to auto-increment the pointer per data byte.
module i2c_target
  import i2c_pkg::*;
#(
  parameter logic [6:0] TARGET_ADDR = DEFAULT_TARGET_ADDR
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe_o,
  output logic [7:0] reg_addr_o,
  output logic [7:0] reg_wdata_o,
  output logic       reg_we_o,
  input  logic [7:0] reg_rdata_i,
  output logic       busy_o
);

  logic scl, scl_rise, scl_fall;
  logic sda, sda_rise, sda_fall;

  i2c_sync_edge u_scl (.clk_i(clk_i), .rst_ni(rst_ni), .d(scl_i),
                       .q(scl), .rise(scl_rise), .fall(scl_fall));
  i2c_sync_edge u_sda (.clk_i(clk_i), .rst_ni(rst_ni), .d(sda_i),
                       .q(sda), .rise(sda_rise), .fall(sda_fall));

  logic start, stop;
  assign start = sda_fall & scl;
  assign stop  = sda_rise & scl;

  state_e     state;
  logic [7:0] shreg;
  logic [3:0] cnt;
  logic       rw;
  logic       rd_ack;
  logic [7:0] rx_byte;

  assign rx_byte = {shreg[6:0], sda};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= IDLE;
      shreg       <= '0;
      cnt         <= '0;
      rw          <= 1'b0;
      rd_ack      <= 1'b0;
      sda_oe_o    <= 1'b0;
      reg_addr_o  <= '0;
      reg_wdata_o <= '0;
      reg_we_o    <= 1'b0;
      busy_o      <= 1'b0;
    end else begin
      reg_we_o <= 1'b0;
`ifdef I2C_TARGET_AUTOINC_EN
      if (reg_we_o) reg_addr_o <= reg_addr_o + 8'd1;
`endif
      if (stop) begin
        state    <= IDLE;
        sda_oe_o <= 1'b0;
        busy_o   <= 1'b0;
        cnt      <= '0;
      end else if (start) begin
        state    <= ADDR;
        sda_oe_o <= 1'b0;
        cnt      <= '0;
      end else begin
        case (state)
          ADDR, REG, WDATA: begin
            if (scl_rise) begin
              shreg <= rx_byte;
              cnt   <= cnt + 4'd1;
              if (cnt == 4'd7 && state == REG) reg_addr_o <= rx_byte;
              if (cnt == 4'd7 && state == WDATA) begin
                reg_wdata_o <= rx_byte;
                reg_we_o    <= 1'b1;
              end
            end else if (scl_fall && cnt == 4'd8) begin
              cnt <= '0;
              if (state == ADDR) begin
                if (shreg[7:1] == TARGET_ADDR) begin
                  state    <= ADDR_ACK;
                  sda_oe_o <= 1'b1;
                  busy_o   <= 1'b1;
                  rw       <= shreg[0];
                end else begin
                  state <= IGNORE;
                end
              end else begin
                state    <= (state == REG) ? REG_ACK : WDATA_ACK;
                sda_oe_o <= 1'b1;
              end
            end
          end
          ADDR_ACK: if (scl_fall) begin
            cnt <= '0;
            if (rw) begin
              state    <= RDATA;
              shreg    <= reg_rdata_i;
              sda_oe_o <= ~reg_rdata_i[7];
            end else begin
              state    <= REG;
              sda_oe_o <= 1'b0;
            end
          end
          REG_ACK, WDATA_ACK: if (scl_fall) begin
            state    <= WDATA;
            sda_oe_o <= 1'b0;
          end
          RDATA: begin
            if (scl_rise) cnt <= cnt + 4'd1;
            else if (scl_fall) begin
              if (cnt == 4'd8) begin
                state    <= RDATA_ACK;
                sda_oe_o <= 1'b0;
                cnt      <= '0;
              end else begin
                shreg    <= {shreg[6:0], 1'b0};
                sda_oe_o <= ~shreg[6];
              end
            end
          end
          RDATA_ACK: begin
            if (scl_rise) begin
              rd_ack <= ~sda;
`ifdef I2C_TARGET_AUTOINC_EN
              // Bump before the next load so reg_rdata_i already follows the new pointer
              if (!sda) reg_addr_o <= reg_addr_o + 8'd1;
`endif
            end else if (scl_fall) begin
              cnt <= '0;
              if (rd_ack) begin
                state    <= RDATA;
                shreg    <= reg_rdata_i;
                sda_oe_o <= ~reg_rdata_i[7];
              end else begin
                state <= IGNORE;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: bit-banged controller on an open-drain bus, reference
// model of pointer/strobe behaviour (honours I2C_TARGET_AUTOINC_EN).
module tb_i2c_target;
  import i2c_pkg::*;

`ifdef I2C_TARGET_AUTOINC_EN
  localparam logic [7:0] INC = 8'd1;
`else
  localparam logic [7:0] INC = 8'd0;
`endif

  logic clk = 1'b0, rst_n = 1'b0, scl = 1'b1, sda_low = 1'b0;
  logic sda, sda_oe, we, busy;
  logic [7:0] addr, wdata, rdata;
  logic [7:0] mem [256];
  logic [7:0] mptr;
  logic [15:0] strobes [$];
  logic [15:0] exp_q [$];
  int oe_cnt = 0, busy_cnt = 0, we_long_cnt = 0;
  logic we_prev = 1'b0;
  int s0, o0, b0;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  assign sda   = ~(sda_low | sda_oe);
  assign rdata = mem[addr];

  i2c_target dut (
    .clk_i(clk), .rst_ni(rst_n), .scl_i(scl), .sda_i(sda), .sda_oe_o(sda_oe),
    .reg_addr_o(addr), .reg_wdata_o(wdata), .reg_we_o(we),
    .reg_rdata_i(rdata), .busy_o(busy)
  );

  always @(negedge clk) begin
    if (we) strobes.push_back({addr, wdata});
    if (we && we_prev) we_long_cnt++;
    we_prev = we;
    if (sda_oe) oe_cnt++;
    if (busy) busy_cnt++;
  end

  task automatic wq();
    repeat (8) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_low = 1'b0; wq(); scl = 1'b1; wq(); sda_low = 1'b1; wq(); scl = 1'b0; wq();
  endtask

  task automatic i2c_stop();
    sda_low = 1'b1; wq(); scl = 1'b1; wq(); sda_low = 1'b0; wq();
  endtask

  task automatic wbit(input logic b);
    sda_low = ~b; wq(); scl = 1'b1; wq(); wq(); scl = 1'b0; wq();
  endtask

  task automatic rbit(output logic b);
    sda_low = 1'b0; wq(); scl = 1'b1; wq(); b = sda; wq(); scl = 1'b0; wq();
  endtask

  // returns the 9th-clock level: 0 = target ACKed
  task automatic wbyte(input logic [7:0] d, output logic nak);
    for (int i = 7; i >= 0; i--) wbit(d[i]);
    rbit(nak);
  endtask

  task automatic rbyte(input logic nak, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin rbit(b); d[i] = b; end
    wbit(nak);
  endtask

  task automatic mark();
    s0 = strobes.size(); o0 = oe_cnt; b0 = busy_cnt;
    exp_q.delete();
  endtask

  task automatic model_write(input logic [7:0] d);
    exp_q.push_back({mptr, d});
    mptr = mptr + INC;
  endtask

  task automatic test_reset();
    total++; if (sda_oe !== 1'b0) begin bad++; $display("FAIL rst_oe: got %b want 0", sda_oe); end
    total++; if (addr !== 8'h00) begin bad++; $display("FAIL rst_addr: got %h want 00", addr); end
    total++; if (wdata !== 8'h00) begin bad++; $display("FAIL rst_wdata: got %h want 00", wdata); end
    total++; if (we !== 1'b0) begin bad++; $display("FAIL rst_we: got %b want 0", we); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
  endtask

  task automatic test_write();
    logic [3:0] nak;
    mark();
    i2c_start();
    wbyte(8'h80, nak[0]); wbyte(8'h06, nak[1]); mptr = 8'h06;
    wbyte(8'hAB, nak[2]); model_write(8'hAB);
    wbyte(8'hCD, nak[3]); model_write(8'hCD);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL wr_busy: got %b want 1", busy); end
    i2c_stop(); wq();
    total++; if (nak !== 4'b0000) begin bad++; $display("FAIL wr_acks: got %b want 0000", nak); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL wr_busy_stop: got %b want 0", busy); end
    total++;
    if (strobes.size() - s0 != exp_q.size()) begin
      bad++; $display("FAIL wr_count: got %0d want %0d", strobes.size() - s0, exp_q.size());
    end else foreach (exp_q[i]) begin
      total++;
      if (strobes[s0+i] !== exp_q[i]) begin bad++; $display("FAIL wr_strobe%0d: got %h want %h", i, strobes[s0+i], exp_q[i]); end
    end
  endtask

  task automatic test_mismatch();
    logic n0, n1;
    mark();
    i2c_start(); wbyte(8'h82, n0); wbyte(8'h06, n1); i2c_stop(); wq();
    total++; if (n0 !== 1'b1) begin bad++; $display("FAIL mm_nak: got %b want 1", n0); end
    total++; if (oe_cnt != o0) begin bad++; $display("FAIL mm_oe: got %0d cycles want 0", oe_cnt - o0); end
    total++; if (strobes.size() != s0) begin bad++; $display("FAIL mm_we: got %0d want 0", strobes.size() - s0); end
    total++; if (busy_cnt != b0) begin bad++; $display("FAIL mm_busy: got %0d cycles want 0", busy_cnt - b0); end
  endtask

  task automatic test_read();
    logic n0, n1, n2;
    logic [7:0] d0, d1, e1;
    mem[8'hFE] = 8'h1E;
    i2c_start(); wbyte(8'h80, n0); wbyte(8'hFE, n1); mptr = 8'hFE;
    i2c_start(); wbyte(8'h81, n2);
    rbyte(1'b0, d0); mptr = mptr + INC;
    total++; if (d0 !== 8'h1E) begin bad++; $display("FAIL rd_byte0: got %h want 1e", d0); end
    total++; if (addr !== mptr) begin bad++; $display("FAIL rd_ptr_ack: got %h want %h", addr, mptr); end
    e1 = mem[mptr];
    rbyte(1'b1, d1);
    total++; if (d1 !== e1) begin bad++; $display("FAIL rd_byte1: got %h want %h", d1, e1); end
    i2c_stop(); wq();
    total++; if ({n0, n1, n2} !== 3'b000) begin bad++; $display("FAIL rd_acks: got %b want 000", {n0, n1, n2}); end
    total++; if (addr !== mptr) begin bad++; $display("FAIL rd_ptr_end: got %h want %h", addr, mptr); end
  endtask

  task automatic test_wrap();
    logic n;
    mark();
    i2c_start(); wbyte(8'h80, n); wbyte(8'hFF, n); mptr = 8'hFF;
    wbyte(8'h11, n); model_write(8'h11);
    wbyte(8'h22, n); model_write(8'h22);
    i2c_stop(); wq();
    total++;
    if (strobes.size() - s0 != exp_q.size()) begin
      bad++; $display("FAIL wrap_count: got %0d want %0d", strobes.size() - s0, exp_q.size());
    end else foreach (exp_q[i]) begin
      total++;
      if (strobes[s0+i] !== exp_q[i]) begin bad++; $display("FAIL wrap_strobe%0d: got %h want %h", i, strobes[s0+i], exp_q[i]); end
    end
  endtask

  task automatic test_abort();
    logic n;
    mark();
    i2c_start(); wbyte(8'h80, n); wbyte(8'h10, n); mptr = 8'h10;
    for (int i = 0; i < 4; i++) wbit(1'($urandom_range(1)));
    i2c_stop(); wq();
    total++; if (strobes.size() != s0) begin bad++; $display("FAIL ab_we: got %0d want 0", strobes.size() - s0); end
    total++; if (dut.state !== IDLE) begin bad++; $display("FAIL ab_state: got %0d want %0d", dut.state, IDLE); end
    total++; if (sda_oe !== 1'b0) begin bad++; $display("FAIL ab_oe: got %b want 0", sda_oe); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL ab_busy: got %b want 0", busy); end
    total++; if (addr !== mptr) begin bad++; $display("FAIL ab_ptr: got %h want %h", addr, mptr); end
  endtask

  task automatic test_reset_mid_ack();
    logic n0, n1, n2;
    int waited = 0;
    i2c_start();
    for (int i = 7; i >= 0; i--) wbit(1'(8'h80 >> i));
    while (sda_oe !== 1'b1 && waited < 40) begin @(negedge clk); waited++; end
    total++; if (sda_oe !== 1'b1) begin bad++; $display("FAIL rm_ack_timeout: got %b want 1", sda_oe); end
    rst_n = 1'b0; #1;
    total++; if (sda_oe !== 1'b0) begin bad++; $display("FAIL rm_oe: got %b want 0", sda_oe); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rm_busy: got %b want 0", busy); end
    total++; if (addr !== 8'h00) begin bad++; $display("FAIL rm_addr: got %h want 00", addr); end
    sda_low = 1'b0; scl = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b1; mptr = 8'h00;
    repeat (4) @(negedge clk);
    mark();
    i2c_start(); wbyte(8'h80, n0); wbyte(8'h33, n1); mptr = 8'h33;
    wbyte(8'h5A, n2); model_write(8'h5A);
    i2c_stop(); wq();
    total++; if ({n0, n1, n2} !== 3'b000) begin bad++; $display("FAIL rm_acks: got %b want 000", {n0, n1, n2}); end
    total++;
    if (strobes.size() - s0 != 1 || strobes[strobes.size()-1] !== exp_q[0]) begin
      bad++; $display("FAIL rm_strobe: got %0d strobes last %h want 1 of %h", strobes.size() - s0, strobes[strobes.size()-1], exp_q[0]);
    end
  endtask

  task automatic test_random();
    logic n;
    logic [7:0] p, d, e;
    int len;
    for (int it = 0; it < 8; it++) begin
      p = 8'($urandom); len = $urandom_range(3, 1);
      mark();
      i2c_start(); wbyte(8'h80, n); wbyte(p, n); mptr = p;
      if ($urandom_range(1) == 0) begin
        for (int k = 0; k < len; k++) begin
          d = 8'($urandom); wbyte(d, n); model_write(d);
          total++; if (n !== 1'b0) begin bad++; $display("FAIL rnd_wr_ack%0d: got %b want 0", it, n); end
        end
      end else begin
        i2c_start(); wbyte(8'h81, n);
        for (int k = 0; k < len; k++) begin
          e = mem[mptr];
          rbyte(k == len - 1, d);
          if (k != len - 1) mptr = mptr + INC;
          total++; if (d !== e) begin bad++; $display("FAIL rnd_rd%0d_%0d: got %h want %h", it, k, d, e); end
        end
      end
      i2c_stop(); wq();
      total++; if (addr !== mptr) begin bad++; $display("FAIL rnd_ptr%0d: got %h want %h", it, addr, mptr); end
      total++;
      if (strobes.size() - s0 != exp_q.size()) begin
        bad++; $display("FAIL rnd_count%0d: got %0d want %0d", it, strobes.size() - s0, exp_q.size());
      end else foreach (exp_q[i]) begin
        total++;
        if (strobes[s0+i] !== exp_q[i]) begin bad++; $display("FAIL rnd_strobe%0d_%0d: got %h want %h", it, i, strobes[s0+i], exp_q[i]); end
      end
    end
    total++; if (we_long_cnt != 0) begin bad++; $display("FAIL we_width: got %0d long pulses want 0", we_long_cnt); end
  endtask

  task automatic test_back_to_back();
    logic n;
    logic [7:0] p0, p1, d0, d1;
    p0 = 8'($urandom); p1 = 8'($urandom); d0 = 8'($urandom); d1 = 8'($urandom);
    mark();
    i2c_start(); wbyte(8'h80, n); wbyte(p0, n); mptr = p0; wbyte(d0, n); model_write(d0);
    i2c_start(); wbyte(8'h80, n); wbyte(p1, n); mptr = p1; wbyte(d1, n); model_write(d1);
    i2c_stop(); wq();
    total++;
    if (strobes.size() - s0 != exp_q.size()) begin
      bad++; $display("FAIL b2b_count: got %0d want %0d", strobes.size() - s0, exp_q.size());
    end else foreach (exp_q[i]) begin
      total++;
      if (strobes[s0+i] !== exp_q[i]) begin bad++; $display("FAIL b2b_strobe%0d: got %h want %h", i, strobes[s0+i], exp_q[i]); end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    test_write();
    test_mismatch();
    test_read();
    test_wrap();
    test_abort();
    test_reset_mid_ack();
    test_random();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
